// File: rtl/niosii_system_irq_ctrl.sv
// rtl/niosii_system_irq_ctrl.sv - Avalon-MM interrupt aggregator: level/edge sources, pending, mask, vector
//
// Optional build macro: IRQ_SYNC_EN
//   defined   : irq_in passes through an extra synchronizer flop before the
//               sample flop, so asynchronous sources are safe (+1 cycle latency).
//   undefined : irq_in is sampled directly and must be synchronous to clk.
//
// Register map (16-bit data, word addresses):
//   0 PENDING  R / W1C     (edge sources only; level sources follow the input)
//   1 MASK     RW
//   2 EDGE     RW          1 = rising-edge source, 0 = level source
//   3 RAW      R           sampled irq_in
//   4 VECTOR   R           bit15 valid, bits3:0 lowest pending&mask index
//   5 SET      W           write-1 sets pending on edge sources, reads 0
//   6,7        read 0, writes ignored

module niosii_system_irq_ctrl #(
   parameter int NUM_IRQ = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               chipselect,
   input  logic [2:0]         address,
   input  logic               write_n,
   input  logic [15:0]        writedata,
   output logic [15:0]        readdata,
   input  logic [NUM_IRQ-1:0] irq_in,
   output logic               irq
);

   localparam logic [2:0] ADDR_PENDING = 3'd0;
   localparam logic [2:0] ADDR_MASK    = 3'd1;
   localparam logic [2:0] ADDR_EDGE    = 3'd2;
   localparam logic [2:0] ADDR_RAW     = 3'd3;
   localparam logic [2:0] ADDR_VECTOR  = 3'd4;
   localparam logic [2:0] ADDR_SET     = 3'd5;

   // Zero-extend a NUM_IRQ-wide field onto the 16-bit data bus.
   function automatic logic [15:0] ext16(input logic [NUM_IRQ-1:0] v);
      logic [15:0] r;
      r = '0;
      r[NUM_IRQ-1:0] = v;
      return r;
   endfunction

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   logic [NUM_IRQ-1:0] in_q,       in_d;       // sampled irq_in (RAW)
   logic [NUM_IRQ-1:0] in_dly_q,   in_dly_d;   // one cycle older copy, for rise detection
   logic [NUM_IRQ-1:0] pending_q,  pending_d;
   logic [NUM_IRQ-1:0] mask_q,     mask_d;
   logic [NUM_IRQ-1:0] edge_q,     edge_d;
   logic [15:0]        readdata_q, readdata_d;

`ifdef IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] s0_q, s0_d;             // synchronizer stage ahead of in_q
`endif

   // ---------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------
   logic               wr;
   logic [NUM_IRQ-1:0] wr_bits;
   logic [NUM_IRQ-1:0] set_bits;
   logic [NUM_IRQ-1:0] clr_bits;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] active;
   logic               vec_valid;
   logic [3:0]         vec_idx;
   logic [15:0]        vector_val;

   // Bus bits above NUM_IRQ are intentionally dropped.
   logic               unused_wdata;

   assign wr           = chipselect && !write_n;
   assign wr_bits      = writedata[NUM_IRQ-1:0];
   assign unused_wdata = ^writedata;

   assign set_bits = (wr && address == ADDR_SET)     ? wr_bits : '0;
   assign clr_bits = (wr && address == ADDR_PENDING) ? wr_bits : '0;

   assign rise   = in_q & ~in_dly_q;
   assign active = pending_q & mask_q;

   // irq is a pure AND/OR of flop outputs, so it cannot glitch on bus activity.
   assign irq      = |active;
   assign readdata = readdata_q;

   // Input sampling chain; the sync stage is only present in the safe build.
   always_comb begin
`ifdef IRQ_SYNC_EN
      s0_d     = irq_in;
      in_d     = s0_q;
`else
      in_d     = irq_in;
`endif
      in_dly_d = in_q;
   end

   // Per-bit pending: level bits mirror the sample, edge bits latch with set priority over clear.
   always_comb begin
      pending_d = pending_q;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (!edge_q[i]) begin
            pending_d[i] = in_q[i];
         end else if (rise[i] || set_bits[i]) begin
            pending_d[i] = 1'b1;
         end else if (clr_bits[i]) begin
            pending_d[i] = 1'b0;
         end
      end
   end

   // MASK and EDGE configuration registers.
   always_comb begin
      mask_d = mask_q;
      edge_d = edge_q;
      if (wr && address == ADDR_MASK) begin
         mask_d = wr_bits;
      end
      if (wr && address == ADDR_EDGE) begin
         edge_d = wr_bits;
      end
   end

   // Lowest-index-first vector: scan downwards so the last hit is the lowest index.
   always_comb begin
      vec_valid = 1'b0;
      vec_idx   = 4'd0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (active[i]) begin
            vec_valid = 1'b1;
            vec_idx   = 4'(i);
         end
      end
      vector_val = {vec_valid, 11'd0, vec_idx};
   end

   // Read mux sees register values before any same-cycle write; it runs every cycle.
   always_comb begin
      readdata_d = 16'h0000;
      case (address)
         ADDR_PENDING: readdata_d = ext16(pending_q);
         ADDR_MASK:    readdata_d = ext16(mask_q);
         ADDR_EDGE:    readdata_d = ext16(edge_q);
         ADDR_RAW:     readdata_d = ext16(in_q);
         ADDR_VECTOR:  readdata_d = vector_val;
         default:      readdata_d = 16'h0000;
      endcase
   end

   // All state flops, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
`ifdef IRQ_SYNC_EN
         s0_q       <= '0;
`endif
         in_q       <= '0;
         in_dly_q   <= '0;
         pending_q  <= '0;
         mask_q     <= '0;
         edge_q     <= '0;
         readdata_q <= 16'h0000;
      end else begin
`ifdef IRQ_SYNC_EN
         s0_q       <= s0_d;
`endif
         in_q       <= in_d;
         in_dly_q   <= in_dly_d;
         pending_q  <= pending_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
      end
   end

endmodule

// File: tb/tb_niosii_system_irq_ctrl.sv
// tb/tb_niosii_system_irq_ctrl.sv - directed self-checking bench for niosii_system_irq_ctrl

module tb_niosii_system_irq_ctrl;

   localparam int NUM_IRQ = 8;

   logic               clk;
   logic               reset_n;
   logic               chipselect;
   logic [2:0]         address;
   logic               write_n;
   logic [15:0]        writedata;
   logic [15:0]        readdata;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq;

   int total = 0;
   int bad   = 0;

   logic [15:0] sb[$];

   niosii_system_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq_in     (irq_in),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_irq(input string tag, input logic exp);
      check(tag, {15'd0, irq}, {15'd0, exp});
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [15:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic reg_read(input string tag, input logic [2:0] a, input logic [15:0] exp);
      logic [15:0] want;
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      sb.push_back(exp);
      step(1);
      chipselect = 1'b0;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, readdata, 16'hxxxx);
      end else begin
         want = sb.pop_front();
         check(tag, readdata, want);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      chipselect = 1'b0;
      address    = 3'd0;
      write_n    = 1'b1;
      writedata  = 16'h0000;
      irq_in     = '0;

      // 1. reset defaults
      step(3);
      check_irq("rst_irq_in_reset", 1'b0);
      reset_n = 1'b1;
      step(2);
      for (int a = 0; a < 6; a++) begin
         reg_read($sformatf("rst_read_%0d", a), 3'(a), 16'h0000);
      end
      check_irq("rst_irq", 1'b0);

      // 2. level source on bit 0
      reg_write(3'd1, 16'h0001);
      irq_in[0] = 1'b1;
      step(1);
      check_irq("lvl_irq_k1", 1'b0);
      step(1);
      check_irq("lvl_irq_k2", 1'b1);
      reg_write(3'd0, 16'h0001);
      reg_read("lvl_w1c_ignored", 3'd0, 16'h0001);
      irq_in[0] = 1'b0;
      step(1);
      check_irq("lvl_fall_k1", 1'b1);
      step(1);
      check_irq("lvl_fall_k2", 1'b0);
      reg_read("lvl_pending_clr", 3'd0, 16'h0000);

      // 3. edge source on bit 2
      reg_write(3'd2, 16'h0004);
      reg_write(3'd1, 16'h0004);
      irq_in[2] = 1'b1;
      step(1);
      irq_in[2] = 1'b0;
      check_irq("edge_irq_k1", 1'b0);
      step(1);
      check_irq("edge_irq_k2", 1'b1);
      reg_read("edge_pending", 3'd0, 16'h0004);
      reg_write(3'd0, 16'h0004);
      check_irq("edge_clr_irq", 1'b0);
      irq_in[2] = 1'b1;
      step(3);
      reg_read("edge_hold_pending", 3'd0, 16'h0004);
      reg_write(3'd0, 16'h0004);
      check_irq("edge_hold_clr_irq", 1'b0);
      step(45);
      check_irq("edge_hold_no_retrigger", 1'b0);
      reg_read("edge_hold_pending0", 3'd0, 16'h0000);
      irq_in[2] = 1'b0;
      step(3);

      // 4. priority vector with edge sources 1 and 6
      reg_write(3'd1, 16'h0000);
      reg_write(3'd2, 16'h0046);
      irq_in[1] = 1'b1;
      irq_in[6] = 1'b1;
      step(1);
      irq_in[1] = 1'b0;
      irq_in[6] = 1'b0;
      step(3);
      reg_write(3'd1, 16'h0040);
      reg_read("vec_mask40", 3'd4, 16'h8006);
      reg_write(3'd1, 16'h0042);
      reg_read("vec_mask42", 3'd4, 16'h8001);
      reg_write(3'd1, 16'h0000);
      reg_read("vec_mask0", 3'd4, 16'h0000);
      check_irq("vec_mask0_irq", 1'b0);
      reg_read("vec_pending", 3'd0, 16'h0042);
      reg_write(3'd0, 16'h0042);
      reg_read("vec_pending_clr", 3'd0, 16'h0000);

      // 5. simultaneous events
      reg_write(3'd2, 16'h0008);
      irq_in[3] = 1'b1;
      step(1);
      reg_write(3'd0, 16'h0008);
      reg_read("sim_set_beats_clr", 3'd0, 16'h0008);
      irq_in[3] = 1'b0;
      reg_write(3'd0, 16'h0008);
      reg_read("sim_clr_after", 3'd0, 16'h0000);
      reg_write(3'd5, 16'h0010);
      reg_read("sim_set_level", 3'd0, 16'h0000);
      reg_write(3'd2, 16'h0018);
      reg_write(3'd5, 16'h0010);
      reg_read("sim_set_edge", 3'd0, 16'h0010);
      reg_read("set_reads0", 3'd5, 16'h0000);

      // boundary: unused bits, unused addresses, RAW
      reg_write(3'd1, 16'hFFFF);
      reg_read("mask_upper_bits", 3'd1, 16'h00FF);
      reg_write(3'd6, 16'hFFFF);
      reg_read("addr6_reads0", 3'd6, 16'h0000);
      reg_read("addr7_reads0", 3'd7, 16'h0000);
      irq_in = 8'h81;
      step(1);
      reg_read("raw", 3'd3, 16'h0081);
      irq_in = '0;
      step(3);

      // 6. asynchronous reset mid-operation
      reg_write(3'd2, 16'h00FF);
      reg_write(3'd5, 16'h00FF);
      reg_write(3'd1, 16'h00FF);
      reg_read("pre_rst_pending", 3'd0, 16'h00FF);
      check_irq("pre_rst_irq", 1'b1);
      #2;
      reset_n = 1'b0;
      #1;
      check_irq("async_rst_irq", 1'b0);
      check("async_rst_readdata", readdata, 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      step(2);
      reg_read("post_rst_pending", 3'd0, 16'h0000);
      reg_read("post_rst_mask", 3'd1, 16'h0000);
      check_irq("post_rst_irq", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
